// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Lets NREQ local requesters share one APB master port. A round-robin
//   arbiter picks an owner. An IDLE/SETUP/ACCESS sequencer then drives the
//   APB bus for that owner. Completion is reported back as a one-cycle done
//   pulse to the owner, together with an error flag and the read data.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   req/wr           per-requester level request and direction (1 = write)
//   addr/wdata       per-requester operands; slice i = [i*AW +: AW] / [i*DW +: DW]
//   gnt              one-hot owner of the transfer on the bus
//   done             one-cycle completion pulse to the owner
//   err              qualified by done: pslverr, or the ACCESS phase timed out
//   rdata            read data of the last completed read
//   psel..pwdata     APB master outputs
//   prdata/pready/pslverr  APB slave responses
//
// Requester handshake: a requester raises req with wr/addr/wdata valid and
// holds all of them stable until it sees its done bit. It drops req in the
// done cycle. The owner's req is masked on the completing edge and during
// the done cycle, so a late drop never causes a second grant of the same
// request.
//
// All outputs are registered. Read the FSM state from the `state` signal.
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // The count value at which one more stalled ACCESS cycle forces the abort.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic            ptr_vld;  // 0 until the first grant, so req[0] is searched first
  logic [CW-1:0]   count;

  logic [NREQ-1:0] arb_req;
  logic [IW-1:0]   start_idx;
  logic [IW-1:0]   arb_idx;
  logic            arb_found;
  logic            timeout_hit;
  logic            complete;

  // In ACCESS the current owner is masked, so a back-to-back pick goes to
  // someone else. In IDLE the previous owner is masked during its done cycle.
  assign arb_req   = (state == ST_ACCESS) ? (req & ~gnt) : (req & ~done);
  assign start_idx = !ptr_vld ? '0 :
                     (ptr == IW'(NREQ - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_found && arb_req[(int'(start_idx) + k) % NREQ]) begin
        arb_found = 1'b1;
        arb_idx   = IW'((int'(start_idx) + k) % NREQ);
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (state == ST_ACCESS) && !pready &&
                       (count == TO_LAST);
  assign complete    = (state == ST_ACCESS) && (pready || timeout_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      ptr_vld <= 1'b0;
      count   <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (arb_found) begin
            pwrite  <= wr[arb_idx];
            paddr   <= addr[arb_idx*AW +: AW];
            pwdata  <= wdata[arb_idx*DW +: DW];
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
            ptr     <= arb_idx;
            ptr_vld <= 1'b1;
            psel    <= 1'b1;
            count   <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (complete) begin
            done    <= gnt;
            err     <= pready ? pslverr : 1'b1;
            if (pready && !pwrite) rdata <= prdata;
            penable <= 1'b0;
            if (arb_found) begin
              // Back-to-back: psel stays high and the next owner goes
              // straight to SETUP.
              pwrite  <= wr[arb_idx];
              paddr   <= addr[arb_idx*AW +: AW];
              pwdata  <= wdata[arb_idx*DW +: DW];
              gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
              ptr     <= arb_idx;
              count   <= '0;
              state   <= ST_SETUP;
            end else begin
              psel  <= 1'b0;
              gnt   <= '0;
              state <= ST_IDLE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]    req   = '0;
  logic [NREQ-1:0]    wr    = '0;
  logic [NREQ*AW-1:0] addr  = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata  = '0;
  logic               pready  = 1'b0;
  logic               pslverr = 1'b0;

  apb_master_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round robin from the spec: search from last winner + 1, first asserted wins.
  function automatic int rr_pick(input logic [NREQ-1:0] elig, input int last);
    int start;
    start = (last < 0) ? 0 : (last + 1) % NREQ;
    for (int k = 0; k < NREQ; k++)
      if (elig[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  // Mostly short wait states, sometimes right around the timeout boundary.
  function automatic int pick_wait();
    if ($urandom_range(0, 9) == 0) return $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
    return $urandom_range(0, 3);
  endfunction

  // ---------------- requester drivers ----------------
  logic [NREQ-1:0] rq_mask = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst) begin
        req[i] = 1'b0;
      end else if (req[i]) begin
        if (done[i]) req[i] = 1'b0;
      end else if (rq_mask[i] && $urandom_range(0, 2) == 0) begin
        wr[i]               = 1'(($urandom_range(0, 1)));
        addr[i*AW +: AW]    = AW'($urandom);
        wdata[i*DW +: DW]   = $urandom;
        req[i]              = 1'b1;
      end
    end
  end

  // ---------------- reference model + APB slave + scoreboard ----------------
  logic [NREQ-1:0] req_e;
  always @(posedge clk) req_e = req;

  logic [NREQ-1:0] exp_q[$];     // owners of granted, not yet completed transfers
  int              cyc;
  int              m_ptr;
  int              m_ts, m_len, m_w, m_owner;
  logic            m_err, m_upd, m_serr, m_wr;
  logic [DW-1:0]   m_prd, m_wdata, m_rdata;
  logic [AW-1:0]   m_addr;
  logic [NREQ-1:0] m_prev_done;
  logic [NREQ-1:0] e_done, elig;
  logic            e_err, arb_now;
  int              kk;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_ptr = -1; m_rdata = '0; m_prev_done = '0; cyc = 0; m_ts = 0; m_len = 0; m_w = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
    end else begin
      cyc++;
      e_done = '0; e_err = 1'b0; elig = '0; arb_now = 1'b0;
      if (exp_q.size() != 0 && cyc == m_ts + m_len + 1) begin
        e_done = exp_q.pop_front();
        e_err  = m_err;
        if (m_upd) m_rdata = m_prd;
        elig    = req_e & ~e_done;
        arb_now = 1'b1;
      end else if (exp_q.size() == 0) begin
        elig    = req_e & ~m_prev_done;
        arb_now = 1'b1;
      end
      if (arb_now && elig != '0) begin
        m_owner = rr_pick(elig, m_ptr);
        m_ptr   = m_owner;
        m_ts    = cyc;
        m_wr    = wr[m_owner];
        m_addr  = addr[m_owner*AW +: AW];
        m_wdata = wdata[m_owner*DW +: DW];
        m_w     = pick_wait();
        m_prd   = $urandom;
        m_serr  = 1'(($urandom_range(0, 3) == 0));
        if (TIMEOUT > 0 && m_w >= TIMEOUT) begin
          m_len = TIMEOUT; m_err = 1'b1; m_upd = 1'b0;
        end else begin
          m_len = m_w + 1; m_err = m_serr; m_upd = !m_wr;
        end
        exp_q.push_back(onehot(m_owner));
      end
      m_prev_done = e_done;

      check("done",  64'(done),  64'(e_done));
      check("err",   64'(err),   64'(e_err));
      check("rdata", 64'(rdata), 64'(m_rdata));
      if (exp_q.size() != 0) begin
        check("psel",    64'(psel),    64'(1'b1));
        check("penable", 64'(penable), 64'(cyc > m_ts));
        check("gnt",     64'(gnt),     64'(exp_q[0]));
        check("paddr",   64'(paddr),   64'(m_addr));
        check("pwrite",  64'(pwrite),  64'(m_wr));
        if (m_wr) check("pwdata", 64'(pwdata), 64'(m_wdata));
      end else begin
        check("psel_idle",    64'(psel),    64'(1'b0));
        check("penable_idle", 64'(penable), 64'(1'b0));
        check("gnt_idle",     64'(gnt),     64'(0));
      end

      // Slave: pready rises in ACCESS cycle m_w; outside ACCESS it is noise.
      if (exp_q.size() != 0 && cyc > m_ts) begin
        kk = cyc - m_ts - 1;
        pready = (kk == m_w);
        if (pready) begin
          prdata = m_prd; pslverr = m_serr;
        end else begin
          prdata = $urandom; pslverr = 1'(($urandom_range(0, 1)));
        end
      end else begin
        pready  = 1'(($urandom_range(0, 1)));
        prdata  = $urandom;
        pslverr = 1'(($urandom_range(0, 1)));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_psel",    64'(psel),    64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_gnt",     64'(gnt),     64'(0));
    check("rst_done",    64'(done),    64'(0));
    check("rst_err",     64'(err),     64'(0));
    check("rst_rdata",   64'(rdata),   64'(0));
    #2 rst = 1'b1;

    rq_mask = 4'b0001; repeat (400)  @(negedge clk);
    rq_mask = 4'b0101; repeat (600)  @(negedge clk);
    rq_mask = 4'b1111; repeat (1500) @(negedge clk);

    // Asynchronous reset in the middle of an ACCESS phase.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (penable === 1'b1) found = 1'b1;
    end
    check("access_seen", 64'(found), 64'(1'b1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_psel",    64'(psel),    64'(0));
    check("mid_rst_penable", 64'(penable), 64'(0));
    check("mid_rst_gnt",     64'(gnt),     64'(0));
    check("mid_rst_done",    64'(done),    64'(0));
    check("mid_rst_err",     64'(err),     64'(0));
    check("mid_rst_rdata",   64'(rdata),   64'(0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    rq_mask = 4'b1111; repeat (800) @(negedge clk);
    rq_mask = 4'b0000; repeat (60)  @(negedge clk);
    check("drain_psel", 64'(psel), 64'(0));
    check("drain_q",    64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
